// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external shift+ALU datapath between two requesters
module alu_arbiter #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0_valid,
   input  logic         req1_valid,
   output logic         req0_ready,
   output logic         req1_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic [2:0]   req0_op,
   input  logic [2:0]   req1_op,
   input  logic [1:0]   req0_sh,
   input  logic [1:0]   req1_sh,
   output logic [W-1:0] dp_a,
   output logic [W-1:0] dp_b,
   output logic [2:0]   dp_ctrl,
   output logic [1:0]   dp_bshift,
   input  logic [W-1:0] dp_result,
   input  logic [3:0]   dp_flags,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_result,
   output logic [3:0]   rsp_flags,
   output logic         busy
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state;
   logic prio, pick1, grant, exec;
   logic [W-1:0] a, b;
   logic [2:0] op;
   logic [1:0] sh;
   // outputs are masked during reset so nothing is offered or reported in that cycle
   always_comb begin
      pick1 = req1_valid && (!req0_valid || prio);
      grant = state == IDLE && !reset && (req0_valid || req1_valid);
      req0_ready = grant && !pick1;
      req1_ready = grant && pick1;
      exec = state == EXEC;
      dp_a = exec ? a : '0;
      dp_b = exec ? b : '0;
      dp_ctrl = exec ? op : '0;
      dp_bshift = exec ? sh : '0;
      busy = state != IDLE && !reset;
      rsp_valid = state == RESP && !reset;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         prio <= 1'b0;
         a <= '0;
         b <= '0;
         op <= '0;
         sh <= '0;
         rsp_id <= 1'b0;
         rsp_result <= '0;
         rsp_flags <= '0;
      end else begin
         unique case (state)
            IDLE: if (grant) begin
               a <= pick1 ? req1_a : req0_a;
               b <= pick1 ? req1_b : req0_b;
               op <= pick1 ? req1_op : req0_op;
               sh <= pick1 ? req1_sh : req0_sh;
               rsp_id <= pick1;
               prio <= !pick1;
               state <= EXEC;
            end
            EXEC: begin
               rsp_result <= dp_result;
               rsp_flags <= dp_flags;
               state <= RESP;
            end
            RESP: if (rsp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector bench; a simple adder stands in for the shared datapath
module tb_alu_arbiter;
   localparam int W = 5;
   logic clk = 1'b0, reset = 1'b1;
   logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
   logic req0_ready, req1_ready, rsp_valid, rsp_id, busy;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [2:0] req0_op = '0, req1_op = '0;
   logic [1:0] req0_sh = '0, req1_sh = '0;
   logic [W-1:0] dp_a, dp_b, dp_result, rsp_result;
   logic [2:0] dp_ctrl;
   logic [1:0] dp_bshift;
   logic [3:0] dp_flags, rsp_flags, flg = '0;
   int nvec = 0, nerr = 0;

   always #5 clk = ~clk;
   assign dp_result = dp_a + dp_b + {dp_ctrl, dp_bshift};
   assign dp_flags = flg;

   alu_arbiter #(.W(W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .req0_op(req0_op), .req1_op(req1_op), .req0_sh(req0_sh), .req1_sh(req1_sh),
      .dp_a(dp_a), .dp_b(dp_b), .dp_ctrl(dp_ctrl), .dp_bshift(dp_bshift),
      .dp_result(dp_result), .dp_flags(dp_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
   );

   typedef struct {
      logic v0, v1;
      logic [4:0] a0, b0;
      logic [2:0] op0;
      logic [1:0] sh0;
      logic [4:0] a1, b1;
      logic [2:0] op1;
      logic [1:0] sh1;
      logic [3:0] flg;
      logic id;
      logic [4:0] res;
   } vec_t;
   vec_t tv[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      req0_valid = v.v0; req1_valid = v.v1;
      req0_a = v.a0; req0_b = v.b0; req0_op = v.op0; req0_sh = v.sh0;
      req1_a = v.a1; req1_b = v.b1; req1_op = v.op1; req1_sh = v.sh1;
      flg = v.flg;
   endtask

   initial begin
      // result = a + b + {op,sh} mod 32; expected grant follows the round-robin pointer starting at 0
      tv[0] = '{1'b1, 1'b0, 5'd3,  5'd5,  3'd0, 2'd0, 5'd9,  5'd9,  3'd1, 2'd1, 4'b0000, 1'b0, 5'd8};
      tv[1] = '{1'b1, 1'b1, 5'd1,  5'd2,  3'd0, 2'd1, 5'd7,  5'd4,  3'd2, 2'd3, 4'b1010, 1'b1, 5'd22};
      tv[2] = '{1'b1, 1'b1, 5'd10, 5'd6,  3'd1, 2'd0, 5'd2,  5'd2,  3'd0, 2'd0, 4'b0101, 1'b0, 5'd20};
      tv[3] = '{1'b1, 1'b1, 5'd0,  5'd0,  3'd0, 2'd0, 5'd31, 5'd31, 3'd7, 2'd3, 4'b1111, 1'b1, 5'd29};
      tv[4] = '{1'b0, 1'b1, 5'd5,  5'd5,  3'd0, 2'd0, 5'd16, 5'd15, 3'd0, 2'd1, 4'b0100, 1'b1, 5'd0};
      tv[5] = '{1'b1, 1'b1, 5'd31, 5'd2,  3'd0, 2'd0, 5'd3,  5'd3,  3'd3, 2'd3, 4'b1000, 1'b0, 5'd1};
      tv[6] = '{1'b1, 1'b0, 5'd4,  5'd4,  3'd4, 2'd0, 5'd0,  5'd0,  3'd0, 2'd0, 4'b0010, 1'b0, 5'd24};
      tv[7] = '{1'b1, 1'b1, 5'd6,  5'd7,  3'd0, 2'd2, 5'd12, 5'd1,  3'd5, 2'd2, 4'b0001, 1'b1, 5'd3};

      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      chk("reset_ready0", req0_ready, 0);
      chk("reset_ready1", req1_ready, 0);
      chk("reset_busy", busy, 0);
      @(negedge clk);
      reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      chk("post_reset_rsp_valid", rsp_valid, 0);
      chk("post_reset_rsp_result", rsp_result, 0);
      chk("post_reset_dp_a", dp_a, 0);

      for (int i = 0; i < 8; i++) begin
         drive(tv[i]);
         #1;
         chk($sformatf("v%0d_ready0", i), req0_ready, tv[i].id == 1'b0);
         chk($sformatf("v%0d_ready1", i), req1_ready, tv[i].id == 1'b1);
         @(negedge clk);
         chk($sformatf("v%0d_exec_busy", i), busy, 1);
         chk($sformatf("v%0d_exec_rsp_valid", i), rsp_valid, 0);
         chk($sformatf("v%0d_exec_ready", i), {req0_ready, req1_ready}, 0);
         chk($sformatf("v%0d_dp_a", i), dp_a, tv[i].id ? tv[i].a1 : tv[i].a0);
         chk($sformatf("v%0d_dp_b", i), dp_b, tv[i].id ? tv[i].b1 : tv[i].b0);
         chk($sformatf("v%0d_dp_ctrl", i), dp_ctrl, tv[i].id ? tv[i].op1 : tv[i].op0);
         chk($sformatf("v%0d_dp_bshift", i), dp_bshift, tv[i].id ? tv[i].sh1 : tv[i].sh0);
         @(negedge clk);
         chk($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
         chk($sformatf("v%0d_rsp_id", i), rsp_id, tv[i].id);
         chk($sformatf("v%0d_rsp_result", i), rsp_result, tv[i].res);
         chk($sformatf("v%0d_rsp_flags", i), rsp_flags, tv[i].flg);
         chk($sformatf("v%0d_resp_dp_a", i), dp_a, 0);
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         chk($sformatf("v%0d_idle_rsp_valid", i), rsp_valid, 0);
         chk($sformatf("v%0d_idle_busy", i), busy, 0);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // backpressure: prio is 0 after tv[7], so req0 wins; hold rsp_ready low for 5 cycles
      drive('{1'b1, 1'b1, 5'd2, 5'd9, 3'd1, 2'd1, 5'd8, 5'd8, 3'd0, 2'd0, 4'b0110, 1'b0, 5'd0});
      #1 chk("bp_grant0", req0_ready, 1);
      @(negedge clk);
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp%0d_rsp_valid", c), rsp_valid, 1);
         chk($sformatf("bp%0d_rsp_id", c), rsp_id, 0);
         chk($sformatf("bp%0d_rsp_result", c), rsp_result, 5'd16);
         chk($sformatf("bp%0d_rsp_flags", c), rsp_flags, 4'b0110);
         chk($sformatf("bp%0d_ready", c), {req0_ready, req1_ready}, 0);
         chk($sformatf("bp%0d_busy", c), busy, 1);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1 chk("bp_release_ready", {req0_ready, req1_ready}, 0);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("bp_idle_busy", busy, 0);
      chk("bp_idle_grant1", req1_ready, 1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1 chk("bp_idle_no_grant", {req0_ready, req1_ready}, 0);

      // reset mid-EXEC: req0 alone leaves prio=1, so a post-reset tie granting req0 shows prio cleared
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 5'd7;
      @(negedge clk);
      req0_valid = 1'b0;
      chk("rst_exec_busy", busy, 1);
      reset = 1'b1;
      #1 chk("rst_during_busy", busy, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("rst%0d_busy", c), busy, 0);
         chk($sformatf("rst%0d_rsp_valid", c), rsp_valid, 0);
         chk($sformatf("rst%0d_dp_a", c), dp_a, 0);
         chk($sformatf("rst%0d_rsp_result", c), rsp_result, 0);
         @(negedge clk);
      end
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1 chk("rst_prio_grant0", req0_ready, 1);
      chk("rst_prio_not1", req1_ready, 0);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      chk("rst_after_rsp_id", rsp_id, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("final_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 5, operand/result width matching the shift+ALU datapath.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have ports req0_valid / req1_valid  input  1 each  requester has an operation pending.
REQ-005 The block SHALL have ports req0_ready / req1_ready  output  1 each  operation accepted this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a, req1_b  input  W each  operands.
REQ-007 The block SHALL have ports req0_op / req1_op  input  3 each  ALUControl code; req0_sh / req1_sh  input  2 each  bshift code.
REQ-008 The block SHALL have ports dp_a, dp_b  output  W each; dp_ctrl  output  3; dp_bshift  output  2  drive to the shared shift+ALU datapath.
REQ-009 The block SHALL have ports dp_result  input  W; dp_flags  input  4  combinational datapath outputs, flags ordered {N,Z,C,V}.
REQ-010 The block SHALL have ports rsp_valid  output  1; rsp_ready  input  1; rsp_id  output  1 (requester index); rsp_result  output  W; rsp_flags  output  4.
REQ-011 The block SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, EXEC, RESP.
REQ-013 In IDLE with at least one reqN_valid, the block SHALL grant exactly one requester, assert its reqN_ready combinationally that cycle, register its a/b/op/sh and index, and move to EXEC.
REQ-014 Grant SHALL be round-robin: if both valid, grant the requester indicated by priority pointer prio (0 or 1); if one valid, grant it regardless of prio.
REQ-015 After every grant, prio SHALL be set to the index not granted.
REQ-016 reqN_ready SHALL be low in EXEC and RESP, and low in IDLE for the non-granted requester.
REQ-017 In EXEC, dp_a/dp_b/dp_ctrl/dp_bshift SHALL equal the registered operands; in all other states they SHALL be zero.
REQ-018 At the end of the EXEC cycle, the block SHALL capture dp_result and dp_flags into rsp_result/rsp_flags, and move to RESP.
REQ-019 In RESP, rsp_valid SHALL be high and rsp_id, rsp_result, rsp_flags SHALL be stable until the cycle rsp_ready is high.
REQ-020 In RESP with rsp_ready high, the block SHALL return to IDLE; a new grant SHALL NOT occur in that same cycle (minimum 3 cycles per operation).
REQ-021 In RESP with rsp_ready low, the block SHALL remain in RESP indefinitely; pending requests SHALL wait.
REQ-022 Latency SHALL be: accept in cycle N, rsp_valid high from cycle N+2.
REQ-023 rsp_valid SHALL be low in IDLE and EXEC.
REQ-024 The block SHALL perform no arithmetic itself; flags SHALL pass through unmodified.

Reset
REQ-025 When reset is high at a clock edge, the block SHALL enter IDLE, set prio to 0, and clear the registered operands, rsp_id, rsp_result and rsp_flags to 0, overriding any other event that cycle.
REQ-026 During and after reset, rsp_valid, busy, req0_ready and req1_ready SHALL be 0 until a new request arrives in IDLE; reset mid-EXEC or mid-RESP SHALL drop the in-flight operation with no response.

Verification
REQ-027 Single request: reset, req0 a=3 b=5 op=add sh=0 -> req0_ready for 1 cycle, dp_* match in cycle N+1, rsp_valid at N+2 with rsp_id=0, rsp_result=datapath value.
REQ-028 Contention: both valid continuously after reset -> grants alternate 0,1,0,1; prio toggles after each grant.
REQ-029 Backpressure: rsp_ready held low 5 cycles in RESP -> rsp_* stable, no req*_ready asserted, state stays RESP; release -> IDLE next cycle.
REQ-030 Lone requester: only req1 valid with prio=0 -> req1 granted immediately, prio becomes 0.
REQ-031 Reset mid-operation: assert reset during EXEC -> next cycle IDLE, rsp_valid=0, dp_*=0, prio=0, no response emitted.
REQ-032 Flag passthrough: drive dp_flags=4'b1010 in EXEC -> rsp_flags=4'b1010 in RESP.
